// File: rtl/seq_divider_8by4.sv
// ---------------------------------------------------------------------------
// seq_divider_8by4
// Sequential unsigned 8-bit by 4-bit restoring divider. It computes one
// quotient bit per clock, so a divide takes 8 CALC cycles. A divisor of zero
// is detected when the operands are accepted and finishes in one cycle.
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; result outputs hold the last result
// CALC   | one restoring step per cycle, 8 steps (cnt 0..7)
// DONE   | done pulse for one cycle; start here is accepted as in IDLE
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   start        request, sampled in IDLE or DONE
//   dividend     8-bit unsigned dividend, captured on the accepting edge
//   divisor      4-bit unsigned divisor, captured on the accepting edge
//   quotient     8-bit quotient, held until the next result
//   remainder    4-bit remainder, held with quotient
//   busy         high in CALC
//   done         one-cycle pulse in DONE
//   div_by_zero  set with the result when the captured divisor was 0
// ---------------------------------------------------------------------------
module seq_divider_8by4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  dvd_q, dvd_d;
    logic [4:0]  prem_q, prem_d;
    logic [3:0]  dsr_q, dsr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  quo_q, quo_d;
    logic [3:0]  rem_q, rem_d;
    logic        dbz_q, dbz_d;

    logic        accept;
    logic [4:0]  trial;
    logic [5:0]  sum;
    logic        carry;
    logic [4:0]  step_prem;
    logic [7:0]  step_dvd;

    // Restoring step: subtract via two's complement; the carry-out out of
    // bit 4 is set exactly when trial >= divisor and becomes the quotient bit.
    always_comb begin
        trial     = {prem_q[3:0], dvd_q[7]};
        sum       = {1'b0, trial} + {1'b0, ~{1'b0, dsr_q}} + 6'd1;
        carry     = sum[5];
        step_prem = carry ? sum[4:0] : trial;
        step_dvd  = {dvd_q[6:0], carry};
    end

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = (divisor == 4'd0) ? S_DONE : S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_q == 3'd7) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_q == S_CALC);
        done = (state_q == S_DONE);
    end

    // Datapath next values
    always_comb begin
        dvd_d  = dvd_q;
        prem_d = prem_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;

        if (accept) begin
            if (divisor != 4'd0) begin
                dvd_d  = dividend;
                dsr_d  = divisor;
                prem_d = 5'd0;
                cnt_d  = 3'd0;
                dbz_d  = 1'b0;
            end else begin
                quo_d  = 8'hFF;
                rem_d  = 4'd0;
                dbz_d  = 1'b1;
            end
        end else if (state_q == S_CALC) begin
            dvd_d  = step_dvd;
            prem_d = step_prem;
            cnt_d  = cnt_q + 3'd1;
            // The last step's results go straight into the output registers.
            if (cnt_q == 3'd7) begin
                quo_d = step_dvd;
                rem_d = step_prem[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_q  <= 8'd0;
            prem_q <= 5'd0;
            dsr_q  <= 4'd0;
            cnt_q  <= 3'd0;
            quo_q  <= 8'd0;
            rem_q  <= 4'd0;
            dbz_q  <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            prem_q <= prem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider_8by4.md
# seq_divider_8by4

Sequential unsigned 8-bit by 4-bit restoring divider. It is the inverse companion of the 4x4 shift-and-add multiplier datapath and shares that block's register / mux / adder style. The block accepts a dividend and a divisor on a start pulse and produces one quotient bit per clock. It returns an 8-bit quotient and a 4-bit remainder with a done pulse. An internal controller FSM and the datapath live in one module.

## Interface
Parameters: none; widths are fixed at 8-bit dividend, 4-bit divisor.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset; clears all state immediately
- start  in  1  request; sampled on a rising edge in IDLE or DONE
- dividend  in  8  unsigned dividend; captured on the accepting edge
- divisor  in  4  unsigned divisor; captured on the accepting edge
- quotient  out  8  result quotient; valid while done=1 and held until the next accepted start
- remainder  out  4  result remainder; same validity as quotient
- busy  out  1  high in CALC
- done  out  1  one-cycle pulse in DONE
- div_by_zero  out  1  high with done when the captured divisor is 0; held with the result

## Operation
- Reset values: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, state=IDLE, step counter=0.
- Internal registers:
  - dvd_q: 8-bit shifting dividend/quotient register.
  - prem: 5-bit partial remainder.
  - dsr: 4-bit divisor.
  - cnt: 3-bit step counter.
- States:
  - IDLE:
    - start=1 and divisor!=0: dvd_q<=dividend, dsr<=divisor, prem<=0, cnt<=0, div_by_zero<=0, go to CALC.
    - start=1 and divisor==0: quotient<=8'hFF, remainder<=0, div_by_zero<=1, go to DONE.
    - start=0: stay in IDLE.
  - CALC, one step per cycle:
    - trial = {prem[3:0], dvd_q[7]}.
    - If trial >= {1'b0,dsr}: prem<=trial-dsr, and dvd_q shifts left with a new LSB of 1.
    - Otherwise: prem<=trial, and dvd_q shifts left with a new LSB of 0.
    - cnt increments.
    - When cnt==7 at the edge, the step completes, quotient/remainder load from the final dvd_q/prem[3:0], and the state goes to DONE.
  - DONE:
    - done=1 for this cycle.
    - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation).
    - Otherwise go to IDLE.
- start in CALC is ignored; operand inputs are don't-care outside the accepting edge.
- Arithmetic: the subtract uses a 5-bit adder in two's-complement form (trial + ~{0,dsr} + 1); carry-out=1 means trial >= divisor.
- The remainder is always < divisor for divisor!=0. Invariant: quotient*divisor + remainder == dividend.

## Timing
- E0 denotes the rising edge on which start is accepted.
- Normal divide:
  - busy=1 from after E0 through E8.
  - Result registers update at E8.
  - done=1 and busy=0 in the cycle after E8.
  - Latency is 8 cycles from accept to result, and 9 edges until the return to IDLE.
- Divide by zero: done=1 in the cycle after E0, with a latency of 1.
- Result outputs change only at the final CALC edge or at a zero-divisor accept, and otherwise hold.
- Asynchronous reset asserted mid-CALC: all outputs go to their reset values without waiting for a clock, and the state goes to IDLE. After release, the first start is handled normally.
- start held high continuously: a new divide is accepted in every DONE cycle, giving a throughput of one result per 9 cycles.

## Test plan
- 200 / 7: done pulses in the cycle after E8, quotient=28, remainder=4, div_by_zero=0; busy is high for exactly 8 cycles.
- 255 / 15 gives quotient=17, remainder=0. 255 / 1 gives quotient=255, remainder=0. 5 / 9 gives quotient=0, remainder=5.
- 13 / 0: done is high in the cycle after E0, quotient=8'hFF, remainder=0, div_by_zero=1, and busy never asserts.
- During 100 / 3, pulse start with 50 / 5 at step 4: the pulse is ignored, the result is 33 r 1, and exactly one done pulse occurs.
- Drop rst low at step 5 of 77 / 6: outputs are cleared at once. After release, 77 / 6 yields 12 r 5.
- Hold start high with 9 / 4 followed by 0 / 3 accepted in the DONE cycle: results are 2 r 1 and then 0 r 0, with done pulses 9 cycles apart.
